// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner and its consumers.
package keypad_pkg;

  // Default matrix geometry and row settle time, shared with the Debounce instance.
  localparam int KP_N          = 5;
  localparam int KP_SETTLE_CYC = 1;

  // Scan FSM states.
  typedef enum logic [1:0] {
    PARK   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } kp_state_e;

  // Flat bit index of key (row r, column c) in the keyboard vector.
  function automatic int key_idx(input int r, input int c);
    return r * KP_N + c;
  endfunction

endpackage

// File: rtl/keypad_ghost_check.sv
// Combinational ghost detector: flags a frame when two distinct rows share
// two or more pressed (low) columns. A three-corner rectangle shows up here
// too, because the phantom fourth corner is physically read as pressed.
module keypad_ghost_check
  import keypad_pkg::*;
#(
  parameter int N = KP_N
) (
  input  logic [N*N-1:0] shadow_i,
  output logic           ghost_o
);

  logic [N-1:0] both_pressed;

  // Scan every row pair; x & (x-1) is non-zero exactly when x has >=2 bits set.
  always_comb begin
    ghost_o      = 1'b0;
    both_pressed = '0;
    for (int a = 0; a < N - 1; a++) begin
      for (int b = a + 1; b < N; b++) begin
        both_pressed = ~shadow_i[a*N +: N] & ~shadow_i[b*N +: N];
        if ((both_pressed & (both_pressed - 1'b1)) != '0) ghost_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: walks the rows one at a time (active-low), samples
// the active-low columns into a shadow frame and publishes ghost-free frames
// on the keyboard output, which feeds Debounce directly.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int N          = KP_N,
  parameter int SETTLE_CYC = KP_SETTLE_CYC
) (
  input  logic           clk_500hz,
  input  logic           rst_n,
  input  logic           scan_en,
  input  logic [N-1:0]   col_n,
  output logic [N-1:0]   row_n,
  output logic [N*N-1:0] keyboard,
  output logic           frame_valid,
  output logic           ghost
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

  kp_state_e      state_q;
  logic [RW-1:0]  row_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   row_n_q;
  logic [N*N-1:0] shadow_q;
  logic [N*N-1:0] shadow_d;
  logic [N*N-1:0] keyboard_q;
  logic           frame_valid_q;
  logic           ghost_q;
  logic           ghost_d;

  // Active-low one-hot drive pattern for a given row.
  function automatic logic [N-1:0] row_drive(input logic [RW-1:0] r);
    return ~({{(N-1){1'b0}}, 1'b1} << r);
  endfunction

  // Shadow with the currently sampled row folded in, so the frame-end edge
  // can judge and publish the complete frame in the same cycle.
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[int'(row_q)*N +: N] = col_n;
  end

  keypad_ghost_check #(.N(N)) u_ghost (
    .shadow_i (shadow_d),
    .ghost_o  (ghost_d)
  );

  // Scan FSM with settle counter, shadow capture and registered outputs.
  always_ff @(posedge clk_500hz) begin
    if (!rst_n) begin
      state_q       <= PARK;
      row_q         <= '0;
      cnt_q         <= '0;
      row_n_q       <= '1;
      shadow_q      <= '1;
      keyboard_q    <= '1;
      frame_valid_q <= 1'b0;
      ghost_q       <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      if (!scan_en) begin
        // Parking discards the partial frame; a re-enable always starts at row 0.
        state_q <= PARK;
        row_q   <= '0;
        cnt_q   <= '0;
        row_n_q <= '1;
      end else begin
        case (state_q)
          PARK: begin
            state_q <= SETTLE;
            row_q   <= '0;
            cnt_q   <= '0;
            row_n_q <= row_drive('0);
          end
          SETTLE: begin
            if (cnt_q == CNT_LAST) begin
              state_q <= SAMPLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          SAMPLE: begin
            shadow_q <= shadow_d;
            state_q  <= SETTLE;
            if (row_q == ROW_LAST) begin
              row_q         <= '0;
              row_n_q       <= row_drive('0);
              frame_valid_q <= 1'b1;
              ghost_q       <= ghost_d;
              if (!ghost_d) keyboard_q <= shadow_d;
            end else begin
              row_q   <= row_q + 1'b1;
              row_n_q <= row_drive(row_q + 1'b1);
            end
          end
          default: begin
            state_q <= PARK;
            row_q   <= '0;
            cnt_q   <= '0;
            row_n_q <= '1;
          end
        endcase
      end
    end
  end

  assign row_n       = row_n_q;
  assign keyboard    = keyboard_q;
  assign frame_valid = frame_valid_q;
  assign ghost       = ghost_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: an electrical model of a diodeless
// key matrix drives the columns, and a frame-level reference predicts every
// published frame, ghost flag and pulse timing.
module tb_keypad_scan;

  localparam int N  = 5;
  localparam int SC = 1;
  localparam int K  = N * N;

  logic           clk_500hz = 1'b0;
  logic           rst_n;
  logic           scan_en;
  logic [N-1:0]   col_n;
  logic [N-1:0]   row_n;
  logic [K-1:0]   keyboard;
  logic           frame_valid;
  logic           ghost;

  logic [K-1:0]   pressed;   // 1 = key physically held
  logic [N-1:0]   glitch;    // forces column lines low when set
  logic [K-1:0]   model_kb;  // expected published frame
  bit             exp_ghost;
  int             checks = 0;
  int             passes = 0;

  always #5 clk_500hz = ~clk_500hz;

  keypad_scan #(.N(N), .SETTLE_CYC(SC)) dut (
    .clk_500hz   (clk_500hz),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .col_n       (col_n),
    .row_n       (row_n),
    .keyboard    (keyboard),
    .frame_valid (frame_valid),
    .ghost       (ghost)
  );

  function automatic int kidx(input int r, input int c);
    return r * N + c;
  endfunction

  // Columns pulled low by a driven row through any chain of closed switches.
  function automatic logic [N-1:0] matrix_cols(input logic [K-1:0] p, input logic [N-1:0] rn);
    logic [N-1:0] rows_low;
    logic [N-1:0] cols_low;
    rows_low = ~rn;
    cols_low = '0;
    for (int it = 0; it < 2 * N; it++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (p[r*N+c] && (rows_low[r] || cols_low[c])) begin
            rows_low[r] = 1'b1;
            cols_low[c] = 1'b1;
          end
    return ~cols_low;
  endfunction

  function automatic logic [K-1:0] expected_frame(input logic [K-1:0] p);
    logic [K-1:0] f;
    logic [N-1:0] drv;
    f = '1;
    for (int r = 0; r < N; r++) begin
      drv = '1;
      drv[r] = 1'b0;
      f[r*N +: N] = matrix_cols(p, drv);
    end
    return f;
  endfunction

  function automatic bit frame_has_ghost(input logic [K-1:0] f);
    int shared;
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++) begin
        shared = 0;
        for (int c = 0; c < N; c++)
          if (!f[a*N+c] && !f[b*N+c]) shared++;
        if (shared >= 2) return 1'b1;
      end
    return 1'b0;
  endfunction

  always_comb col_n = matrix_cols(pressed, row_n) & ~glitch;

  task automatic step();
    @(negedge clk_500hz);
  endtask

  task automatic wait_pulse(output int n, output bit seen);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 30) begin
      step();
      n++;
      if (frame_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic model_publish();
    logic [K-1:0] f;
    f = expected_frame(pressed);
    exp_ghost = frame_has_ghost(f);
    if (!exp_ghost) model_kb = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan_en = 1'b0; pressed = '0; glitch = '0;
    model_kb = '1; exp_ghost = 1'b0;
    repeat (3) step();
    checks++; if (row_n !== 5'b11111) $display("FAIL reset_row_n: got %b want 11111", row_n); else passes++;
    checks++; if (keyboard !== {K{1'b1}}) $display("FAIL reset_keyboard: got %h want %h", keyboard, {K{1'b1}}); else passes++;
    checks++; if (frame_valid !== 1'b0) $display("FAIL reset_frame_valid: got %b want 0", frame_valid); else passes++;
    checks++; if (ghost !== 1'b0) $display("FAIL reset_ghost: got %b want 0", ghost); else passes++;
    scan_en = 1'b1;
    step();
    checks++; if (row_n !== 5'b11111) $display("FAIL reset_dominates_en: got %b want 11111", row_n); else passes++;
  endtask

  task automatic test_idle_scan();
    logic [N-1:0] exp_row;
    bit exp_fv;
    rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step();
      exp_row = ~(5'b00001 << (((k - 1) / 2) % N));
      exp_fv = (k > 1) && ((k - 1) % 10 == 0);
      checks++; if (row_n !== exp_row) $display("FAIL idle_row_n[%0d]: got %b want %b", k, row_n, exp_row); else passes++;
      checks++; if (frame_valid !== exp_fv) $display("FAIL idle_fv[%0d]: got %b want %b", k, frame_valid, exp_fv); else passes++;
      if (exp_fv) begin
        model_publish();
        checks++; if (keyboard !== {K{1'b1}}) $display("FAIL idle_kb[%0d]: got %h want all ones", k, keyboard); else passes++;
        checks++; if (ghost !== 1'b0) $display("FAIL idle_ghost[%0d]: got %b want 0", k, ghost); else passes++;
      end
    end
  endtask

  task automatic test_single_key();
    logic [K-1:0] want;
    int n; bit seen;
    for (int i = 0; i < 2; i++) begin
      pressed = '0;
      want = '1;
      if (i == 0) begin
        pressed[kidx(2, 3)] = 1'b1;
        want[13] = 1'b0;
      end
      wait_pulse(n, seen);
      model_publish();
      checks++; if (!seen || n != 10) $display("FAIL single_period[%0d]: got %0d cycles want 10", i, n); else passes++;
      checks++; if (keyboard !== want) $display("FAIL single_kb[%0d]: got %h want %h", i, keyboard, want); else passes++;
      checks++; if (keyboard !== model_kb) $display("FAIL single_model[%0d]: got %h want %h", i, keyboard, model_kb); else passes++;
      checks++; if (ghost !== 1'b0) $display("FAIL single_ghost[%0d]: got %b want 0", i, ghost); else passes++;
    end
  endtask

  task automatic test_ghost();
    logic [K-1:0] pats [4];
    logic [K-1:0] want [4];
    bit           wg   [4];
    int n; bit seen;
    pats[0] = '0; pats[0][kidx(0, 2)] = 1'b1;
    pats[1] = '0; pats[1][kidx(1, 0)] = 1'b1; pats[1][kidx(1, 4)] = 1'b1;
    pats[1][kidx(3, 0)] = 1'b1; pats[1][kidx(3, 4)] = 1'b1;
    pats[2] = pats[1]; pats[2][kidx(3, 4)] = 1'b0;
    pats[3] = pats[2]; pats[3][kidx(3, 0)] = 1'b0;
    want[0] = '1; want[0][2] = 1'b0;
    want[1] = want[0];
    want[2] = want[0];
    want[3] = '1; want[3][5] = 1'b0; want[3][9] = 1'b0;
    wg[0] = 1'b0; wg[1] = 1'b1; wg[2] = 1'b1; wg[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pressed = pats[i];
      wait_pulse(n, seen);
      model_publish();
      checks++; if (!seen || n != 10) $display("FAIL ghost_period[%0d]: got %0d cycles want 10", i, n); else passes++;
      checks++; if (ghost !== wg[i]) $display("FAIL ghost_flag[%0d]: got %b want %b", i, ghost, wg[i]); else passes++;
      checks++; if (keyboard !== want[i]) $display("FAIL ghost_kb[%0d]: got %h want %h", i, keyboard, want[i]); else passes++;
      checks++; if (keyboard !== model_kb || ghost !== exp_ghost) $display("FAIL ghost_model[%0d]: got %h/%b want %h/%b", i, keyboard, ghost, model_kb, exp_ghost); else passes++;
    end
  endtask

  task automatic test_random();
    int n; bit seen;
    for (int i = 0; i < 10; i++) begin
      pressed = '0;
      repeat ($urandom_range(0, 4)) pressed[$urandom_range(0, K - 1)] = 1'b1;
      wait_pulse(n, seen);
      model_publish();
      checks++; if (!seen || n != 10) $display("FAIL rand_period[%0d]: got %0d cycles want 10", i, n); else passes++;
      checks++; if (keyboard !== model_kb) $display("FAIL rand_kb[%0d]: got %h want %h (keys %h)", i, keyboard, model_kb, pressed); else passes++;
      checks++; if (ghost !== exp_ghost) $display("FAIL rand_ghost[%0d]: got %b want %b (keys %h)", i, ghost, exp_ghost, pressed); else passes++;
    end
  endtask

  task automatic test_drop_row3();
    logic [K-1:0] held;
    bit exp_fv;
    pressed = '0; pressed[kidx(4, 4)] = 1'b1;
    held = model_kb;
    repeat (6) step();
    checks++; if (row_n !== 5'b10111) $display("FAIL drop3_pre_row: got %b want 10111", row_n); else passes++;
    scan_en = 1'b0;
    step();
    checks++; if (row_n !== 5'b11111) $display("FAIL drop3_park: got %b want 11111", row_n); else passes++;
    for (int k = 0; k < 12; k++) begin
      checks++; if (frame_valid !== 1'b0 || keyboard !== held) $display("FAIL drop3_quiet[%0d]: got fv=%b kb=%h want fv=0 kb=%h", k, frame_valid, keyboard, held); else passes++;
      step();
    end
    scan_en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      exp_fv = (k == 11);
      if (k == 1) begin
        checks++; if (row_n !== 5'b11110) $display("FAIL drop3_restart_row: got %b want 11110", row_n); else passes++;
      end
      checks++; if (frame_valid !== exp_fv) $display("FAIL drop3_fv[%0d]: got %b want %b", k, frame_valid, exp_fv); else passes++;
    end
    model_publish();
    checks++; if (keyboard !== model_kb) $display("FAIL drop3_kb: got %h want %h", keyboard, model_kb); else passes++;
  endtask

  task automatic test_drop_last();
    logic [K-1:0] held;
    int n; bit seen;
    pressed = '0; pressed[kidx(0, 0)] = 1'b1;
    held = model_kb;
    repeat (9) step();
    checks++; if (row_n !== 5'b01111) $display("FAIL droplast_pre_row: got %b want 01111", row_n); else passes++;
    scan_en = 1'b0;
    step();
    checks++; if (frame_valid !== 1'b0) $display("FAIL droplast_fv: got %b want 0", frame_valid); else passes++;
    checks++; if (row_n !== 5'b11111) $display("FAIL droplast_row: got %b want 11111", row_n); else passes++;
    checks++; if (keyboard !== held) $display("FAIL droplast_kb: got %h want %h", keyboard, held); else passes++;
    step();
    scan_en = 1'b1;
    wait_pulse(n, seen);
    model_publish();
    checks++; if (!seen || n != 11) $display("FAIL droplast_restart: got %0d cycles want 11", n); else passes++;
    checks++; if (keyboard !== model_kb) $display("FAIL droplast_pub: got %h want %h", keyboard, model_kb); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [K-1:0] want;
    int n; bit seen;
    pressed = '0; pressed[kidx(2, 2)] = 1'b1;
    wait_pulse(n, seen);
    model_publish();
    want = '1; want[12] = 1'b0;
    checks++; if (keyboard !== want) $display("FAIL rstmid_pre_kb: got %h want %h", keyboard, want); else passes++;
    pressed = '0; pressed[kidx(4, 1)] = 1'b1;
    repeat (9) step();
    rst_n = 1'b0;
    step();
    model_kb = '1; exp_ghost = 1'b0;
    checks++; if (row_n !== 5'b11111) $display("FAIL rstmid_row: got %b want 11111", row_n); else passes++;
    checks++; if (keyboard !== {K{1'b1}}) $display("FAIL rstmid_kb: got %h want all ones", keyboard); else passes++;
    checks++; if (frame_valid !== 1'b0) $display("FAIL rstmid_fv: got %b want 0", frame_valid); else passes++;
    checks++; if (ghost !== 1'b0) $display("FAIL rstmid_ghost: got %b want 0", ghost); else passes++;
    rst_n = 1'b1;
    wait_pulse(n, seen);
    model_publish();
    checks++; if (!seen || n != 11) $display("FAIL rstmid_restart: got %0d cycles want 11", n); else passes++;
    checks++; if (keyboard !== model_kb) $display("FAIL rstmid_pub: got %h want %h", keyboard, model_kb); else passes++;
  endtask

  task automatic test_glitch();
    int n; bit seen;
    pressed = '0;
    glitch = 5'b00010;
    step();
    glitch = '0;
    wait_pulse(n, seen);
    model_publish();
    checks++; if (!seen || n != 9) $display("FAIL glitch_period: got %0d cycles want 9", n); else passes++;
    checks++; if (keyboard[1] !== 1'b1) $display("FAIL glitch_bit1: got %b want 1", keyboard[1]); else passes++;
    checks++; if (keyboard !== model_kb) $display("FAIL glitch_kb: got %h want %h", keyboard, model_kb); else passes++;
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_key();
    test_ghost();
    test_random();
    test_drop_row3();
    test_drop_last();
    test_reset_mid();
    test_glitch();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
